// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared rho offsets, state typedefs and lane index helper
//
// Purpose: constants and helpers shared by the lane-serial rho engine.
//   RHO_OFFSETS[x][y] : rho rotation offsets, reduced mod 64.
//   lane_t / state_t  : full-width (64-bit) lane and 5x5 state types.
//   lane_xy(k)        : maps the serial lane counter k (0..24) to x=k%5, y=k/5.
package keccak_pkg;

  localparam int LANE_W_MAX = 64;

  typedef logic [LANE_W_MAX-1:0] lane_t;
  typedef lane_t [4:0][4:0]      state_t;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
  } lane_xy_t;

  typedef enum logic [1:0] {
    RHO_IDLE = 2'd0,
    RHO_RUN  = 2'd1,
    RHO_DONE = 2'd2
  } rho_fsm_e;

  // Indexed [x][y].
  localparam logic [5:0] RHO_OFFSETS [5][5] = '{
    '{6'd0,  6'd36, 6'd3,  6'd41, 6'd18},
    '{6'd1,  6'd44, 6'd10, 6'd45, 6'd2 },
    '{6'd62, 6'd6,  6'd43, 6'd15, 6'd61},
    '{6'd28, 6'd55, 6'd25, 6'd21, 6'd56},
    '{6'd27, 6'd20, 6'd39, 6'd8,  6'd14}
  };

  function automatic lane_xy_t lane_xy(input logic [4:0] k);
    lane_xy_t r;
    r.x = 3'(k % 5'd5);
    r.y = 3'(k / 5'd5);
    return r;
  endfunction

endpackage

// File: rtl/keccak_lane_rotl.sv
// rtl/keccak_lane_rotl.sv - combinational left barrel rotator for one lane
//
// Purpose: rotate a w-bit lane toward the MSB.
// Ports:
//   lane    in  [w-1:0] lane to rotate
//   amount  in  [5:0]   rotate amount, taken mod w (w is a power of two <= 64)
//   rotated out [w-1:0] lane rotated left by amount mod w
module keccak_lane_rotl #(
  parameter int w = 64
) (
  input  logic [w-1:0] lane,
  input  logic [5:0]   amount,
  output logic [w-1:0] rotated
);

  logic [5:0] sh;
  logic [6:0] rsh;

  // w is a power of two, so mod w is a mask.
  assign sh  = amount & 6'(w - 1);
  // For sh=0 the right shift is by w and yields zero, leaving the lane unchanged.
  assign rsh = 7'(w) - {1'b0, sh};

  assign rotated = (lane << sh) | (lane >> rsh);

endmodule

// File: rtl/keccak_rho_inv_seq.sv
// rtl/keccak_rho_inv_seq.sv - lane-serial rho / inverse-rho engine, one lane per cycle
//
// Purpose: apply rho (inverse=0) or rho^-1 (inverse=1) to a 5x5 state using a
// single shared rotator, one lane per cycle, with valid/ready on both sides.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready only in IDLE
//   in_state              input state [x][y][z]
//   inverse               1 = rho^-1, 0 = rho; captured with in_state
//   out_valid / out_ready output handshake; out_valid only in DONE
//   out_state             result state, zero outside DONE
//   busy                  high in RUN or DONE
module keccak_rho_inv_seq
  import keccak_pkg::*;
#(
  parameter int w = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [4:0][4:0][w-1:0]    in_state,
  input  logic                      inverse,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4:0][4:0][w-1:0]    out_state,
  output logic                      busy
);

  rho_fsm_e                  state_q, state_d;
  logic [4:0]                k_q, k_d;
  logic [4:0][4:0][w-1:0]    st_q, st_d;
  logic                      mode_q, mode_d;

  lane_xy_t                  xy;
  logic [5:0]                off;
  logic [5:0]                amt;
  logic [w-1:0]              cur_lane;
  logic [w-1:0]              rot_lane;

  assign xy       = lane_xy(k_q);
  assign off      = RHO_OFFSETS[xy.x][xy.y];
  assign cur_lane = st_q[xy.x][xy.y];
  // Inverse is a left rotate by (w - s) mod w. Since w divides 64,
  // (64 - r) mod 64 reduced mod w equals that, so 6-bit negation suffices.
  assign amt      = mode_q ? (6'd0 - off) : off;

  keccak_lane_rotl #(.w(w)) u_rotl (
    .lane    (cur_lane),
    .amount  (amt),
    .rotated (rot_lane)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RHO_IDLE;
      k_q     <= '0;
      st_q    <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      st_q    <= st_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    st_d      = st_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    busy      = 1'b0;

    case (state_q)
      RHO_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_state;
          mode_d  = inverse;
          k_d     = '0;
          state_d = RHO_RUN;
        end
      end
      RHO_RUN: begin
        busy = 1'b1;
        st_d[xy.x][xy.y] = rot_lane;
        if (k_q == 5'd24) begin
          k_d     = '0;
          state_d = RHO_DONE;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      RHO_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_state = st_q;
        if (out_ready) begin
          state_d = RHO_IDLE;
        end
      end
      default: begin
        state_d = RHO_IDLE;
        k_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_keccak_rho_inv_seq.sv
// tb/tb_keccak_rho_inv_seq.sv - self-checking bench for keccak_rho_inv_seq
module tb_keccak_rho_inv_seq;

  typedef logic [4:0][4:0][63:0] st64_t;
  typedef logic [4:0][4:0][7:0]  st8_t;

  localparam int RHO [5][5] = '{
    '{0, 36, 3, 41, 18},
    '{1, 44, 10, 45, 2},
    '{62, 6, 43, 15, 61},
    '{28, 55, 25, 21, 56},
    '{27, 20, 39, 8, 14}
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n;
  logic  in_valid, in_ready, inverse, out_valid, out_ready, busy;
  st64_t in_state, out_state;

  logic  v8, rdy8, inv8, ov8, ordy8, busy8;
  st8_t  s8, o8;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  st64_t exp_q[$];
  int    acc_q[$];
  int    acc_log[$];
  bit    prev_ov = 1'b0;

  keccak_rho_inv_seq #(.w(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state), .inverse(inverse),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
  );

  keccak_rho_inv_seq #(.w(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_state(s8), .inverse(inv8),
    .out_valid(ov8), .out_ready(ordy8), .out_state(o8), .busy(busy8)
  );

  // Bit-level definition: forward moves bit z to (z+s) mod w, inverse to (z-s) mod w.
  function automatic logic [63:0] rot_model(input logic [63:0] lane, input int x, input int y,
                                            input int wd, input bit inv);
    logic [63:0] o;
    int s;
    o = '0;
    s = RHO[x][y] % wd;
    for (int z = 0; z < wd; z++) begin
      int d;
      d = inv ? (z - s + wd) % wd : (z + s) % wd;
      o[d] = lane[z];
    end
    return o;
  endfunction

  function automatic st64_t model64(input st64_t s, input bit inv);
    st64_t r;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        r[x][y] = rot_model(s[x][y], x, y, 64, inv);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_st(input string name, input st64_t act, input st64_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int x = 0; x < 5; x++)
        for (int y = 0; y < 5; y++)
          if (act[x][y] !== exp[x][y]) begin
            $display("FAIL %s lane(%0d,%0d) got %h want %h", name, x, y, act[x][y], exp[x][y]);
            return;
          end
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout got none want event", name);
  endtask

  // Compare process: scoreboard of model results, in-order, checked every DONE cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
    end else begin
      chk("excl_valid_ready", 64'(out_valid & in_ready), 64'd0);
      chk("busy_vs_ready", 64'(busy), 64'(!in_ready));
      if (in_valid && in_ready) begin
        exp_q.push_back(model64(in_state, inverse));
        acc_q.push_back(cyc);
        acc_log.push_back(cyc);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got out_valid want none");
        end else begin
          chk_st("out_state", out_state, exp_q[0]);
          if (!prev_ov) chk("latency", 64'(cyc - acc_q[0]), 64'd26);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic accept64(input st64_t s, input bit inv, input bit keep);
    bit ok;
    ok = 1'b0;
    in_state = s;
    inverse  = inv;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("accept64");
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic get64(output st64_t r);
    bit ok;
    ok = 1'b0;
    r = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        r = out_state;
        break;
      end
    end
    if (!ok) timeout("get64");
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input st8_t s, input bit inv, output st8_t r);
    bit ok;
    ok = 1'b0;
    r = '0;
    s8 = s;
    inv8 = inv;
    v8 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout("run8_accept");
    @(posedge clk);
    #1;
    v8 = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ov8) begin
        ok = 1'b1;
        r = o8;
        break;
      end
    end
    if (!ok) timeout("run8_out");
    @(posedge clk);
    #1;
  endtask

  function automatic st64_t rand_state();
    st64_t s;
    for (int x = 0; x < 5; x++)
      for (int y = 0; y < 5; y++)
        s[x][y] = {$urandom, $urandom};
    return s;
  endfunction

  initial begin
    st64_t a, b, e, r, fwd, back, snap;
    st8_t  t8, r8;
    int    base;

    rst_n = 1'b0;
    in_valid = 1'b0; in_state = '0; inverse = 1'b0; out_ready = 1'b1;
    v8 = 1'b0; s8 = '0; inv8 = 1'b0; ordy8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_state", 64'(out_state != '0), 64'd0);
    chk("rst8_in_ready", 64'(rdy8), 64'd1);
    chk("rst8_out_state", 64'(o8), 64'd0);
    @(posedge clk);
    #1;

    // Pin the model with hand-computed values
    a = '0;
    a[1][0] = 64'h1;
    e = '0;
    e[1][0] = 64'h8000_0000_0000_0000;
    chk_st("model_pin_inv", model64(a, 1'b1), e);
    chk("model_pin_fwd", rot_model(64'h1, 1, 0, 64, 1'b0), 64'h2);
    chk("model_pin_w8_inv", rot_model(64'h1, 2, 0, 8, 1'b1), 64'h04);
    chk("model_pin_w8_fwd", rot_model(64'h1, 2, 0, 8, 1'b0), 64'h40);

    // Single-lane inverse
    accept64(a, 1'b1, 1'b0);
    get64(r);
    chk_st("single_lane_inv", r, e);

    // Reduced width w=8
    t8 = '0;
    t8[2][0] = 8'h01;
    run8(t8, 1'b1, r8);
    chk("w8_inv_lane20", 64'(r8[2][0]), 64'h04);
    chk("w8_inv_others", 64'(r8 & ~(st8_t'(8'hff) << (8 * 10))), 64'd0);
    run8(t8, 1'b0, r8);
    chk("w8_fwd_lane20", 64'(r8[2][0]), 64'h40);

    // Round trip with random states
    for (int i = 0; i < 20; i++) begin
      a = rand_state();
      accept64(a, 1'b0, 1'b0);
      get64(fwd);
      accept64(fwd, 1'b1, 1'b0);
      get64(back);
      chk_st("roundtrip", back, a);
      chk("lane00_passthru", fwd[0][0], a[0][0]);
    end

    // Backpressure in DONE
    a = rand_state();
    b = rand_state();
    out_ready = 1'b0;
    accept64(a, 1'b1, 1'b0);
    snap = '0;
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 100; n++) begin
        @(negedge clk);
        if (out_valid) begin
          ok = 1'b1;
          snap = out_state;
          break;
        end
      end
      if (!ok) timeout("bp_out_valid");
    end
    chk_st("bp_snapshot", snap, model64(a, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_state = b; inverse = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk_st("bp_out_stable", out_state, snap);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_after_in_ready", 64'(in_ready), 64'd1);
    chk("bp_after_busy", 64'(busy), 64'd0);
    chk("bp_not_captured", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset in the middle of RUN
    a = rand_state();
    accept64(a, 1'b1, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_out_state", 64'(out_state != '0), 64'd0);
    @(posedge clk);
    #1;
    a = rand_state();
    accept64(a, 1'b0, 1'b0);
    get64(r);
    chk_st("mrst_new_state", r, model64(a, 1'b0));

    // Back-to-back with in_valid held and out_ready tied high
    acc_log.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rand_state();
      accept64(a, i[0], 1'b1);
    end
    in_valid = 1'b0;
    begin
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (exp_q.size() == 0 && !busy) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) timeout("b2b_drain");
    end
    chk("b2b_accepts", 64'(acc_log.size()), 64'd3);
    if (acc_log.size() == 3) begin
      base = acc_log[0];
      chk("b2b_gap1", 64'(acc_log[1] - base), 64'd27);
      chk("b2b_gap2", 64'(acc_log[2] - acc_log[1]), 64'd27);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_rho_inv_seq.md
# keccak_rho_inv_seq

Lane-serial ρ-step engine for the Keccak datapath. It applies the inverse ρ rotation, or the forward ρ rotation when selected, to a full 5×5 state one lane per cycle using a single shared rotator. Valid/ready handshakes sit on both the input and output sides. The block is the undo path for the combinational ρ stage, used by the inverse-permutation and round-trip self-check logic.

## Interface
- w, 64, lane width in bits; legal values are 1, 2, 4, 8, 16, 32, 64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  an input state is offered.
- in_ready  out  1  block can accept a state.
- in_state  in  [4:0][4:0][w-1:0]  state indexed [x][y][z].
- inverse  in  1  1 = ρ⁻¹, 0 = ρ; sampled with in_state.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  [4:0][4:0][w-1:0]  result state.
- busy  out  1  state is RUN or DONE.

## Operation
- Offsets r[x][y], reduced mod 64:
  - x=0: 0,36,3,41,18
  - x=1: 1,44,10,45,2
  - x=2: 62,6,43,15,61
  - x=3: 28,55,25,21,56
  - x=4: 27,20,39,8,14
- Effective amount: s = r[x][y] mod w. This is valid because w divides 64.
- Forward ρ: bit z moves to bit (z+s) mod w, i.e. rotate toward MSB.
- ρ⁻¹: bit z moves to bit (z−s) mod w, i.e. rotate toward LSB.
- Implement ρ⁻¹ as a left rotation by (w−s) mod w so that one rotator serves both modes.
- FSM states:
  - IDLE: in_ready=1. When in_valid && in_ready, load in_state into the state register, latch inverse into a mode register, clear lane counter k to 0, and go to RUN.
  - RUN: each cycle, rotate lane (x=k%5, y=k/5) in place in the register, then increment k. After k=24 is processed, go to DONE. Lanes with s=0 still consume a cycle, so latency is fixed.
  - DONE: out_valid=1 and out_state=register. When out_valid && out_ready, go to IDLE.
- Inputs while busy: in_ready=0; in_valid and in_state are ignored.
- out_state is stable throughout DONE, regardless of how long out_ready is held low.
- Counter k is 5 bits. It never wraps past 24 and is 0 outside RUN.
- Reset, including reset in the middle of RUN or DONE: state goes to IDLE, k=0, and register and mode are cleared to 0. No partially rotated result is ever presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0.
- Accept at edge T. RUN covers edges T+1 … T+25. out_valid is high starting the cycle after edge T+25.
- There is no same-cycle bypass. After the output handshake at edge U, in_ready is high in the cycle following U.
- If out_ready is high when DONE is entered, the transfer completes on the first DONE edge.
- Best-case throughput is one state per 27 cycles.
- out_valid and in_ready are never high in the same cycle.

## Structure
- keccak_pkg holds: RHO_OFFSETS[5][5] (mod-64 table above), the lane_t and state_t typedefs, and a function lane_xy(k) returning x and y.
- Sub-module keccak_lane_rotl: combinational left barrel rotator with parameter w, inputs lane and amount (6 bits, taken mod w), output rotated lane. Instantiated once.
- The FSM, counter, state register and mode register live in the top module.

## Test plan
- Single-lane inverse: w=64, inverse=1, lane (1,0)=64'h1, all other lanes 0 → out lane (1,0)=64'h8000_0000_0000_0000, all other lanes 0; out_valid rises 26 cycles after accept.
- Reduced width: w=8, inverse=1, lane (2,0)=8'h01 (s=62 mod 8=6) → lane (2,0)=8'h04. Also inverse=0 on the same input → 8'h40.
- Round trip: w=64, 20 random states. Run forward (inverse=0), feed out_state back with inverse=1 → result equals the original state bit-exactly. A zero-offset lane (0,0) passes through unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_state and out_valid stable, in_ready=0. Drive in_valid=1 with a different state during this window → it is ignored and not captured.
- Reset mid-run: assert rst_n=0 for 1 cycle at RUN cycle 10 → the next cycle shows in_ready=1, busy=0, out_valid=0, out_state=0. A new state then completes normally with correct data.
- Back-to-back: out_ready tied to 1, in_valid held at 1 with three states → accepts are spaced 27 cycles apart, and all three results are correct and in order.
